// File: rtl/vedic_mult_seq.sv
// Sequential unsigned multiplier built around a single 2x2 Vedic cell.
// Each operand is split into WIDTH/2 two-bit digits; one digit pair is
// multiplied per RUN cycle and the shifted partial product is summed into
// a 2*WIDTH accumulator, so a full product takes (WIDTH/2)^2 cycles.
// Optional build macro: VEDIC_SEQ_ZERO_SKIP_EN. When it is defined, a zero
// operand finishes straight away with a zero product.

// 2x2 Vedic (Urdhva Tiryagbhyam) cell: vertical and crosswise bit products.
module vedic_multu2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic cross_carry;

  assign cross_carry = a[1] & b[0] & a[0] & b[1];
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ cross_carry;
  assign p[3] = a[1] & b[1] & cross_carry;

endmodule

module vedic_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int D     = WIDTH / 2;
  localparam int STEPS = D * D;
  localparam int KW    = $clog2(STEPS);
  localparam int IW    = $clog2(D);

  localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);
  localparam logic [IW-1:0] D_LAST = IW'(D - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [KW-1:0]        k;
  // di/dj track k/D and k%D incrementally so no divider is needed when D
  // is not a power of two.
  logic [IW-1:0]        di;
  logic [IW-1:0]        dj;

  logic [1:0]           a_dig;
  logic [1:0]           b_dig;
  logic [3:0]           cell_p;
  logic [IW:0]          dig_sum;
  logic [2*WIDTH-1:0]   term;
  logic [2*WIDTH-1:0]   acc_next;

  // Digit selection and partial-product alignment for the current step.
  assign a_dig    = 2'(a_reg >> {di, 1'b0});
  assign b_dig    = 2'(b_reg >> {dj, 1'b0});
  assign dig_sum  = {1'b0, di} + {1'b0, dj};
  assign term     = (2*WIDTH)'(cell_p) << {dig_sum, 1'b0};
  // The true sum never exceeds a*b < 2^(2*WIDTH), so dropping the carry is exact.
  assign acc_next = acc + term;

  vedic_multu2 u_cell (
    .a (a_dig),
    .b (b_dig),
    .p (cell_p)
  );

  // Control FSM with registered handshake outputs and the datapath registers.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      k         <= '0;
      di        <= '0;
      dj        <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            k     <= '0;
            di    <= '0;
            dj    <= '0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
              state     <= DONE;
              product   <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
`else
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`endif
          end
        end

        RUN: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (dj == D_LAST) begin
            dj <= '0;
            di <= di + 1'b1;
          end else begin
            dj <= dj + 1'b1;
          end
          if (k == K_LAST) begin
            state     <= DONE;
            product   <= acc_next;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          // Returning to IDLE costs one edge, so new operands can only be
          // accepted on the following edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vedic_mult_seq.md
VEDIC_MULT_SEQ -- requirements
Module: vedic_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; WIDTH SHALL be even and >= 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port a, input, WIDTH, the unsigned multiplicand.
REQ-005 SHALL have port b, input, WIDTH, the unsigned multiplier.
REQ-006 SHALL have port in_valid, input, 1, meaning operands are valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-008 SHALL have port product, output, 2*WIDTH, the unsigned result.
REQ-009 SHALL have port out_valid, output, 1, meaning product is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts product.
REQ-011 SHALL have port busy, output, 1, high while state is RUN.

Function
REQ-012 SHALL contain exactly one instance of the 2x2 Vedic cell vedic_multu2; all partial products SHALL come from it, time-multiplexed.
REQ-013 SHALL use a 3-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE, in_valid=1: SHALL latch a and b, clear the accumulator and step counter, and go to RUN; with in_valid=0 it SHALL stay in IDLE.
REQ-016 Digits: D=WIDTH/2; step k in 0..D*D-1 SHALL select a-digit i=k/D and b-digit j=k%D (2-bit digits, LSB digit 0).
REQ-017 Each RUN cycle SHALL add the 4-bit cell result, zero-extended and shifted left by 2*(i+j), into a 2*WIDTH accumulator, then increment k.
REQ-018 The accumulator SHALL never overflow; no carry out of 2*WIDTH bits SHALL be generated or kept.
REQ-019 After the step k=D*D-1 is accumulated, the FSM SHALL enter DONE.
REQ-020 out_valid SHALL rise exactly D*D edges after the accepting edge (16 for WIDTH=8).
REQ-021 In DONE, product SHALL equal a*b of the accepted operands and SHALL hold stable while out_ready=0.
REQ-022 DONE, out_ready=1: SHALL return to IDLE on that edge; the next operands SHALL NOT be accepted on the same edge.
REQ-023 a, b and in_valid SHALL be ignored outside IDLE; changing them during RUN SHALL NOT affect the result.
REQ-024 product SHALL keep its last value in IDLE and RUN until it is overwritten in DONE.

Reset
REQ-025 While rst=1, the block SHALL immediately, without a clock, enter IDLE with product=0, out_valid=0, busy=0, in_ready=1, k=0 and the accumulator at 0.
REQ-026 Reset mid-RUN or in DONE SHALL abandon the operation; no out_valid SHALL follow for it.

Configuration
REQ-027 Macro VEDIC_SEQ_ZERO_SKIP_EN SHALL control zero-skip.
REQ-028 With VEDIC_SEQ_ZERO_SKIP_EN defined: on acceptance with a=0 or b=0, the FSM SHALL go directly to DONE with product=0, so out_valid rises 1 edge after acceptance and busy stays 0.
REQ-029 Without VEDIC_SEQ_ZERO_SKIP_EN: zero operands SHALL take the full D*D cycles like any other operands.

Verification (WIDTH=8)
REQ-030 a=8'hFF, b=8'hFF, in_valid pulse, out_ready=1 -> out_valid 16 edges after acceptance, product=16'hFE01, 1 cycle, then in_ready=1.
REQ-031 a=8'd13, b=8'd11, out_ready=0 for 5 cycles after out_valid -> product=16'd143 held stable with out_valid=1 until the out_ready edge.
REQ-032 a=0, b=8'h5A -> zero-skip build: out_valid after 1 edge, product=0; normal build: out_valid after 16 edges, product=0.
REQ-033 rst asserted at RUN step k=7 -> outputs reset immediately, no out_valid; the next a=3, b=2 -> product=6 after 16 edges.
REQ-034 a and b toggled randomly during RUN after accepting 8'hA5 and 8'h3C -> product=16'h26AC.
REQ-035 Back-to-back in_valid=1 held with out_ready=1 for 100 random pairs -> every product equals a*b, each accept is spaced 18 edges from the previous one, and there is no accept in DONE.
